// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Merges load-use, MDU-occupancy and taken-branch hazards into the PC / IF-ID
// write enables, the ID-EX bubble, the IF-ID flush and the MDU launch pulse.
// It also keeps a saturating count of the cycles spent inserting bubbles.
module pipeline_stall_controller #(
   parameter int MDU_LATENCY = 4,   // busy cycles after mdu_start, legal 2..15
   parameter int CNT_W       = 16   // width of the stall_cycles counter
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rt,
   input  logic [4:0]       if_id_rs,
   input  logic [4:0]       if_id_rt,
   input  logic             if_id_uses_rt,
   input  logic             if_id_is_mdu,
   input  logic             if_id_reads_hilo,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             mdu_start,
   output logic             mdu_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MDU_BUSY = 1'b1
   } state_t;

   // Counter reload value: the counter runs MDU_LATENCY-1 down to 0, so the
   // busy state spans exactly MDU_LATENCY cycles.
   localparam logic [3:0]       MDU_LOAD = 4'(MDU_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t     state, state_next;
   logic [3:0] mdu_cnt, mdu_cnt_next;

   logic rs_match;
   logic rt_match;
   logic load_use;
   logic hilo_hz;

   // Register $zero is never a real load destination, so it never raises a hazard.
   assign rs_match = (id_ex_rt == if_id_rs);
   assign rt_match = if_id_uses_rt & (id_ex_rt == if_id_rt);
   assign load_use = id_ex_mem_read & (id_ex_rt != 5'd0) & (rs_match | rt_match);

   // A second MDU op or a HI/LO read must wait while the unit is still working.
   assign hilo_hz  = (state == MDU_BUSY) & (if_id_is_mdu | if_id_reads_hilo);

   // Prioritised hazard resolution plus next-state logic for the MDU tracker.
   always_comb begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      mdu_start    = 1'b0;
      state_next   = state;
      mdu_cnt_next = mdu_cnt;

      if (reset) begin
         // Everything held low; registers are cleared on this edge.
      end else if (branch_taken) begin
         // The ID instruction is on the wrong path: squash it and never let
         // it launch the MDU.
         pc_write    = 1'b1;
         if_id_write = 1'b1;
         if_id_flush = 1'b1;
      end else if (load_use || hilo_hz) begin
         id_ex_bubble = 1'b1;
      end else begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
         mdu_start   = if_id_is_mdu & (state == IDLE);
      end

      // The in-flight MDU op is older than any branch or stall, so it keeps
      // counting regardless of what the front end is doing.
      case (state)
         IDLE: begin
            if (mdu_start) begin
               state_next   = MDU_BUSY;
               mdu_cnt_next = MDU_LOAD;
            end
         end
         MDU_BUSY: begin
            if (mdu_cnt == 4'd0) begin
               state_next = IDLE;
            end else begin
               mdu_cnt_next = mdu_cnt - 4'd1;
            end
         end
         default: begin
            state_next   = IDLE;
            mdu_cnt_next = 4'd0;
         end
      endcase
   end

   // State, MDU counter, registered busy flag and saturating stall counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         mdu_cnt      <= 4'd0;
         mdu_busy     <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state    <= state_next;
         mdu_cnt  <= mdu_cnt_next;
         mdu_busy <= (state_next == MDU_BUSY);
         if (id_ex_bubble && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios with
// literal expectations, a long saturation run, then randomized traffic, all
// compared every cycle against a behavioural model.
module tb_pipeline_stall_controller;

   localparam int LAT     = 4;
   localparam int CNT_W   = 16;
   localparam int CNT_TOP = 65535;

   logic             clk = 1'b0;
   logic             reset;
   logic             id_ex_mem_read;
   logic [4:0]       id_ex_rt;
   logic [4:0]       if_id_rs;
   logic [4:0]       if_id_rt;
   logic             if_id_uses_rt;
   logic             if_id_is_mdu;
   logic             if_id_reads_hilo;
   logic             branch_taken;
   logic             pc_write;
   logic             if_id_write;
   logic             id_ex_bubble;
   logic             if_id_flush;
   logic             mdu_start;
   logic             mdu_busy;
   logic [CNT_W-1:0] stall_cycles;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model state: remaining MDU busy cycles and the stall count as plain integers.
   int m_rem = 0;
   int m_cnt = 0;

   pipeline_stall_controller #(.MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .id_ex_mem_read   (id_ex_mem_read),
      .id_ex_rt         (id_ex_rt),
      .if_id_rs         (if_id_rs),
      .if_id_rt         (if_id_rt),
      .if_id_uses_rt    (if_id_uses_rt),
      .if_id_is_mdu     (if_id_is_mdu),
      .if_id_reads_hilo (if_id_reads_hilo),
      .branch_taken     (branch_taken),
      .pc_write         (pc_write),
      .if_id_write      (if_id_write),
      .id_ex_bubble     (id_ex_bubble),
      .if_id_flush      (if_id_flush),
      .mdu_start        (mdu_start),
      .mdu_busy         (mdu_busy),
      .stall_cycles     (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Expected combinational outputs {pc_write, if_id_write, bubble, flush, start}
   // derived straight from the hazard priority rules.
   function automatic logic [4:0] model_out();
      bit lu, busy;
      lu = id_ex_mem_read && (id_ex_rt != 0) &&
           ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
      busy = (m_rem > 0);
      if (reset)                                         return 5'b00000;
      if (branch_taken)                                  return 5'b11010;
      if (lu || (busy && (if_id_is_mdu || if_id_reads_hilo))) return 5'b00100;
      return {4'b1100, (if_id_is_mdu && !busy)};
   endfunction

   // Advance the model on each rising edge using the inputs held during the cycle.
   always @(posedge clk) begin
      logic [4:0] e;
      e = model_out();
      if (reset) begin
         m_rem = 0;
         m_cnt = 0;
      end else begin
         if (e[0])          m_rem = LAT;
         else if (m_rem > 0) m_rem = m_rem - 1;
         if (e[2] && m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
      end
   end

   // Per-cycle comparison of every output against the model, mid-cycle.
   always @(negedge clk) begin
      logic [4:0] e;
      if (chk_en) begin
         e = model_out();
         cmp("pc_write",     int'(pc_write),     int'(e[4]));
         cmp("if_id_write",  int'(if_id_write),  int'(e[3]));
         cmp("id_ex_bubble", int'(id_ex_bubble), int'(e[2]));
         cmp("if_id_flush",  int'(if_id_flush),  int'(e[1]));
         cmp("mdu_start",    int'(mdu_start),    int'(e[0]));
         cmp("mdu_busy",     int'(mdu_busy),     (m_rem > 0) ? 1 : 0);
         cmp("stall_cycles", int'(stall_cycles), m_cnt);
      end
   end

   task automatic clear_in();
      id_ex_mem_read   = 1'b0;
      id_ex_rt         = 5'd0;
      if_id_rs         = 5'd0;
      if_id_rt         = 5'd0;
      if_id_uses_rt    = 1'b0;
      if_id_is_mdu     = 1'b0;
      if_id_reads_hilo = 1'b0;
      branch_taken     = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int busy_seen;
      reset = 1'b1;
      clear_in();
      next_cycle();
      chk_en = 1'b1;
      reset  = 1'b0;

      // 1: lw $t0 in EX, add with rs=$t0 in ID stalls one cycle.
      id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8; if_id_rt = 5'd3;
      @(negedge clk);
      cmp("t1_pc_write", int'(pc_write), 0);
      cmp("t1_if_id_write", int'(if_id_write), 0);
      cmp("t1_bubble", int'(id_ex_bubble), 1);
      next_cycle();
      clear_in();
      @(negedge clk);
      cmp("t1_count", int'(stall_cycles), 1);
      cmp("t1_resume", int'(pc_write), 1);
      next_cycle();

      // 2: $zero destination never stalls; rt match ignored unless rt is read.
      id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
      @(negedge clk);
      cmp("t2_zero_reg", int'(id_ex_bubble), 0);
      next_cycle();
      id_ex_rt = 5'd9; if_id_rs = 5'd1; if_id_rt = 5'd9; if_id_uses_rt = 1'b0;
      @(negedge clk);
      cmp("t2_rt_unused", int'(id_ex_bubble), 0);
      next_cycle();
      if_id_uses_rt = 1'b1;
      @(negedge clk);
      cmp("t2_rt_used", int'(id_ex_bubble), 1);
      next_cycle();
      clear_in();

      // 3: mult launches, mfhi right behind it waits out the four busy cycles.
      if_id_is_mdu = 1'b1;
      @(negedge clk);
      cmp("t3_start", int'(mdu_start), 1);
      next_cycle();
      if_id_is_mdu = 1'b0; if_id_reads_hilo = 1'b1;
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         cmp("t3_busy", int'(mdu_busy), 1);
         cmp("t3_stall", int'(id_ex_bubble), 1);
         cmp("t3_no_restart", int'(mdu_start), 0);
         next_cycle();
      end
      @(negedge clk);
      cmp("t3_issue", int'(pc_write), 1);
      cmp("t3_idle", int'(mdu_busy), 0);
      cmp("t3_count", int'(stall_cycles), 6);
      next_cycle();
      clear_in();

      // 4: taken branch outranks load-use and suppresses the MDU launch.
      branch_taken = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
      if_id_is_mdu = 1'b1;
      @(negedge clk);
      cmp("t4_flush", int'(if_id_flush), 1);
      cmp("t4_bubble", int'(id_ex_bubble), 0);
      cmp("t4_start", int'(mdu_start), 0);
      cmp("t4_pc_write", int'(pc_write), 1);
      next_cycle();
      clear_in();
      @(negedge clk);
      cmp("t4_count", int'(stall_cycles), 6);
      cmp("t4_no_busy", int'(mdu_busy), 0);
      next_cycle();

      // 5: reset in the second busy cycle abandons the op.
      if_id_is_mdu = 1'b1;
      next_cycle();
      if_id_is_mdu = 1'b0;
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      cmp("t5_rst_pc", int'(pc_write), 0);
      cmp("t5_rst_ifid", int'(if_id_write), 0);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      cmp("t5_busy_clr", int'(mdu_busy), 0);
      cmp("t5_count_clr", int'(stall_cycles), 0);
      next_cycle();
      if_id_is_mdu = 1'b1;
      @(negedge clk);
      cmp("t5_restart", int'(mdu_start), 1);
      next_cycle();
      if_id_is_mdu = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < LAT + 3; i++) begin
         @(negedge clk);
         if (mdu_busy) busy_seen++;
         next_cycle();
      end
      cmp("t5_busy_len", busy_seen, LAT);

      // 6: hold a load-use hazard long enough to saturate the counter.
      id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; if_id_rs = 5'd7;
      repeat (65540) next_cycle();
      @(negedge clk);
      cmp("t6_saturate", int'(stall_cycles), 65535);
      next_cycle();
      clear_in();

      // Randomized traffic with a narrow register range to provoke matches.
      for (int i = 0; i < 3000; i++) begin
         reset            = ($urandom_range(0, 49) == 0);
         id_ex_mem_read   = ($urandom_range(0, 9) < 3);
         id_ex_rt         = 5'($urandom_range(0, 3));
         if_id_rs         = 5'($urandom_range(0, 3));
         if_id_rt         = 5'($urandom_range(0, 3));
         if_id_uses_rt    = 1'($urandom_range(0, 1));
         if_id_is_mdu     = ($urandom_range(0, 9) < 2);
         if_id_reads_hilo = ($urandom_range(0, 9) < 2);
         branch_taken     = ($urandom_range(0, 9) == 0);
         next_cycle();
      end
      reset = 1'b0;
      clear_in();
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
